// File: rtl/vga_frame_capture.sv
// vga_frame_capture: grabs one (or every) active VGA frame into a
// first-word-fall-through FIFO and drains it through a valid/ready stream.
//
// Ports:
//   clock_25            pixel clock, rising edge
//   reset               asynchronous active-low reset
//   display_on          active-video qualifier from the sync generator
//   pixel_x, pixel_y    current raster coordinates
//   R, G, B             pixel colour channels
//   arm                 one-cycle request to capture the next frame
//   out_valid/out_ready stream handshake; a pixel moves when both are high
//   out_data            {R,G,B} of the head pixel
//   out_sof, out_eol    head pixel is (0,0) / last column of its line
//   busy                waiting for start of frame or capturing
//   frame_done          one-cycle pulse after the last pixel is pushed
//   overflow            sticky: a pixel was dropped since the last arm
//   drop_count          number of dropped pixels, saturating
module vga_frame_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CH_BITS    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CONTINUOUS = 0
) (
    input  logic                   clock_25,
    input  logic                   reset,
    input  logic                   display_on,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic [CH_BITS-1:0]     R,
    input  logic [CH_BITS-1:0]     G,
    input  logic [CH_BITS-1:0]     B,
    input  logic                   arm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*CH_BITS-1:0]   out_data,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 3*CH_BITS + 2;
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_sof;
    logic          w_in_range;
    logic          w_last;
    logic          w_push_req;
    logic          w_arm_clr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_head;

    assign w_sof      = display_on && (pixel_x == '0) && (pixel_y == '0);
    assign w_in_range = display_on && (pixel_x <= X_LAST)
                        && (pixel_y <= Y_LAST);
    assign w_last     = (pixel_x == X_LAST) && (pixel_y == Y_LAST);

    // Extra MSB on each pointer tells full (MSBs differ) from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW])
                     && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = out_valid && out_ready;
    // A full FIFO still takes a pixel when the head leaves on the same edge.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && !w_push;

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid  = !w_empty;
    assign out_data   = out_valid ? w_head[3*CH_BITS-1:0] : '0;
    assign out_eol    = out_valid && w_head[DW-2];
    assign out_sof    = out_valid && w_head[DW-1];
    assign busy       = (r_state == S_WAIT_SOF) || (r_state == S_CAPTURE);
    assign frame_done = (r_state == S_DONE);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_push_req = 1'b0;
        w_arm_clr  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_next    = S_WAIT_SOF;
                    w_arm_clr = 1'b1;
                end
            end
            S_WAIT_SOF: begin
                if (w_sof) begin
                    w_push_req = 1'b1;
                    w_next     = w_last ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_in_range) begin
                    w_push_req = 1'b1;
                    if (w_last) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = (CONTINUOUS != 0) ? S_WAIT_SOF : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the outputs are gated by out_valid.
    always_ff @(posedge clock_25) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_sof, (pixel_x == X_LAST), R, G, B};
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (w_arm_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: scenario table, hand sequences and random
// traffic checked against a queue-based frame-grabber model.
module tb_vga_frame_capture;

    localparam int H = 4;
    localparam int V = 3;
    localparam int CHB = 4;
    localparam int DEPTH = 4;

    logic        clock_25;
    logic        reset;
    logic        display_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [3:0]  R, G, B;
    logic        arm;
    logic        out_ready;

    logic        n_valid, n_sof, n_eol, n_busy, n_done, n_ovf;
    logic [11:0] n_data;
    logic [15:0] n_drops;
    logic        c_valid, c_sof, c_eol, c_busy, c_done, c_ovf;
    logic [11:0] c_data;
    logic [15:0] c_drops;

    vga_frame_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CH_BITS(CHB),
        .FIFO_DEPTH(DEPTH), .CONTINUOUS(0)
    ) dut (
        .clock_25(clock_25), .reset(reset), .display_on(display_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .R(R), .G(G), .B(B),
        .arm(arm), .out_valid(n_valid), .out_ready(out_ready),
        .out_data(n_data), .out_sof(n_sof), .out_eol(n_eol),
        .busy(n_busy), .frame_done(n_done), .overflow(n_ovf),
        .drop_count(n_drops)
    );

    vga_frame_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CH_BITS(CHB),
        .FIFO_DEPTH(DEPTH), .CONTINUOUS(1)
    ) dut_c (
        .clock_25(clock_25), .reset(reset), .display_on(display_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .R(R), .G(G), .B(B),
        .arm(arm), .out_valid(c_valid), .out_ready(out_ready),
        .out_data(c_data), .out_sof(c_sof), .out_eol(c_eol),
        .busy(c_busy), .frame_done(c_done), .overflow(c_ovf),
        .drop_count(c_drops)
    );

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    bit m_cont;

    logic        s_valid, s_sof, s_eol, s_busy, s_done, s_ovf;
    logic [11:0] s_data;
    logic [15:0] s_drops;
    assign s_valid = m_cont ? c_valid : n_valid;
    assign s_sof   = m_cont ? c_sof   : n_sof;
    assign s_eol   = m_cont ? c_eol   : n_eol;
    assign s_busy  = m_cont ? c_busy  : n_busy;
    assign s_done  = m_cont ? c_done  : n_done;
    assign s_ovf   = m_cont ? c_ovf   : n_ovf;
    assign s_data  = m_cont ? c_data  : n_data;
    assign s_drops = m_cont ? c_drops : n_drops;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: pixel queue plus "armed"/"in frame"/"done" flags.
    logic [13:0] mq[$];
    bit m_wait, m_cap, m_done, m_ovf;
    int m_drops;

    int outs, dones, sofs, eols;
    bit got_first, first_sof;
    int first_data;

    typedef struct {
        bit cont;
        bit rdy;
        int arm_y;
        int nf;
        int e_outs;
        int e_dones;
        int e_sofs;
        int e_eols;
        int e_drops;
        bit e_ovf;
        bit e_fsof;
    } scen_t;

    scen_t tbl[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_wait = 0;
        m_cap = 0;
        m_done = 0;
        m_ovf = 0;
        m_drops = 0;
    endtask

    task automatic stats_clear();
        outs = 0;
        dones = 0;
        sofs = 0;
        eols = 0;
        got_first = 0;
        first_sof = 0;
        first_data = 0;
    endtask

    task automatic model_step(input bit disp, input int x, input int y,
                              input logic [11:0] rgb, input bit a,
                              input bit rdy);
        bit pop, sof, inr, last, req;
        pop  = (mq.size() > 0) && rdy;
        sof  = disp && x == 0 && y == 0;
        inr  = disp && x < H && y < V;
        last = (x == H-1) && (y == V-1);
        req  = (m_wait && sof) || (m_cap && inr);
        if (pop) void'(mq.pop_front());
        if (req) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({sof, (x == H-1), rgb});
            end else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        if (m_done) begin
            m_done = 0;
            m_wait = m_cont;
        end else if (m_wait) begin
            if (sof) begin
                m_wait = 0;
                if (last) m_done = 1;
                else m_cap = 1;
            end
        end else if (m_cap) begin
            if (inr && last) begin
                m_cap = 0;
                m_done = 1;
            end
        end else if (a) begin
            m_wait = 1;
            m_ovf = 0;
            m_drops = 0;
        end
    endtask

    // Called at a falling edge: apply inputs, compare, advance one clock.
    task automatic cyc(input bit disp, input int x, input int y,
                       input logic [11:0] rgb, input bit a, input bit rdy);
        display_on = disp;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        {R, G, B} = rgb;
        arm = a;
        out_ready = rdy;
        chk("valid", s_valid, mq.size() > 0);
        if (mq.size() > 0) chk("head", {s_sof, s_eol, s_data}, mq[0]);
        chk("busy", s_busy, m_wait || m_cap);
        chk("frame_done", s_done, m_done);
        chk("overflow", s_ovf, m_ovf);
        chk("drop_count", s_drops, m_drops);
        if (s_valid && rdy) begin
            if (!got_first) begin
                got_first = 1;
                first_sof = s_sof;
                first_data = s_data;
            end
            outs++;
            sofs += s_sof;
            eols += s_eol;
        end
        if (s_done) dones++;
        model_step(disp, x, y, rgb, a, rdy);
        @(posedge clock_25);
        @(negedge clock_25);
    endtask

    task automatic idle(input int n, input bit rdy, input bit a);
        for (int i = 0; i < n; i++) begin
            cyc(0, H+1, V, 12'($urandom), a && i == 0, rdy);
        end
    endtask

    task automatic frames(input int nf, input bit rdy, input int arm_y);
        for (int f = 0; f < nf; f++) begin
            for (int y = 0; y <= V; y++) begin
                for (int x = 0; x < H+2; x++) begin
                    bit disp, a;
                    disp = x < H && y < V;
                    a = arm_y >= 0 && f == 0 && y == arm_y && x == 0;
                    cyc(disp, x, y,
                        disp ? 12'(x + 4*y) : 12'($urandom), a, rdy);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock_25);
        reset = 0;
        display_on = 0;
        arm = 0;
        out_ready = 0;
        model_clear();
        stats_clear();
        @(posedge clock_25);
        @(negedge clock_25);
        reset = 1;
    endtask

    initial begin
        reset = 0;
        display_on = 0;
        pixel_x = 0;
        pixel_y = 0;
        {R, G, B} = 12'h0;
        arm = 0;
        out_ready = 0;
        m_cont = 0;
        model_clear();
        stats_clear();

        tbl[0] = '{1'b0, 1'b1, -1, 2, 12, 1, 1, 3, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, -1, 1, 0, 1, 0, 0, 8, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1, 2, 12, 1, 1, 3, 0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, -1, 3, 36, 3, 3, 9, 0, 1'b0, 1'b1};

        // Reset state.
        do_reset();
        chk("rst_valid", s_valid, 0);
        chk("rst_data", s_data, 0);
        chk("rst_sof", s_sof, 0);
        chk("rst_eol", s_eol, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_drops", s_drops, 0);

        // Scenario table.
        for (int i = 0; i < 4; i++) begin
            m_cont = tbl[i].cont;
            do_reset();
            if (tbl[i].arm_y < 0) idle(1, tbl[i].rdy, 1);
            frames(tbl[i].nf, tbl[i].rdy, tbl[i].arm_y);
            idle(8, tbl[i].rdy, 0);
            chk($sformatf("s%0d_outs", i), outs, tbl[i].e_outs);
            chk($sformatf("s%0d_dones", i), dones, tbl[i].e_dones);
            chk($sformatf("s%0d_sofs", i), sofs, tbl[i].e_sofs);
            chk($sformatf("s%0d_eols", i), eols, tbl[i].e_eols);
            chk($sformatf("s%0d_drops", i), s_drops, tbl[i].e_drops);
            chk($sformatf("s%0d_ovf", i), s_ovf, tbl[i].e_ovf);
            if (tbl[i].e_outs > 0) begin
                chk($sformatf("s%0d_first_sof", i), first_sof, tbl[i].e_fsof);
            end else begin
                chk($sformatf("s%0d_hold_data", i), s_data, 0);
                chk($sformatf("s%0d_hold_valid", i), s_valid, 1);
            end
        end

        // Full FIFO: push and pop on the same edge keeps all four entries.
        m_cont = 0;
        do_reset();
        idle(1, 0, 1);
        for (int x = 0; x < H; x++) cyc(1, x, 0, 12'(x), 0, 0);
        cyc(1, 0, 1, 12'(4), 0, 1);
        stats_clear();
        for (int i = 0; i < 8; i++) cyc(0, H+1, 1, 12'hABC, 0, 1);
        chk("full_occupancy", outs, 4);
        chk("full_head", first_data, 1);
        chk("full_drops", s_drops, 0);
        chk("full_ovf", s_ovf, 0);

        // Reset in the middle of a capture.
        do_reset();
        idle(1, 0, 1);
        for (int x = 0; x < H; x++) cyc(1, x, 0, 12'(x), 0, 0);
        cyc(1, 0, 1, 12'(4), 0, 0);
        chk("pre_rst_drops", s_drops, 1);
        display_on = 1;
        pixel_x = 10'd1;
        pixel_y = 10'd1;
        reset = 0;
        #1;
        chk("midrst_valid", s_valid, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_drops", s_drops, 0);
        chk("midrst_ovf", s_ovf, 0);
        model_clear();
        stats_clear();
        @(posedge clock_25);
        @(negedge clock_25);
        reset = 1;
        frames(1, 1, -1);
        idle(4, 1, 0);
        chk("midrst_no_outs", outs, 0);
        chk("midrst_no_done", dones, 0);

        // Random traffic, one-shot then continuous.
        for (int part = 0; part < 2; part++) begin
            m_cont = bit'(part);
            do_reset();
            for (int f = 0; f < 8; f++) begin
                for (int y = 0; y <= V; y++) begin
                    for (int x = 0; x < H+2; x++) begin
                        bit disp;
                        disp = x < H && y < V && ($urandom % 8 != 0);
                        cyc(disp, x, y, 12'($urandom),
                            ($urandom % 12) == 0, ($urandom % 4) != 0);
                    end
                end
            end
            idle(12, 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
